// File: rtl/instr_fetch_queue_if.sv
// Fetch-to-decode queue bundle.
//   flush               : discard every queued entry
//   push_valid/vaddr/instr/ex (x2), push_ready : fetch side, two slots per cycle
//   pop_valid/vaddr/instr/ex (x2), pop_ack     : decode side, first-word fall-through
//   count               : current number of valid entries
// slave  = the queue itself; master = the fetch/decode environment.
interface instr_fetch_queue_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            flush;
  logic [1:0]      push_valid;
  logic [31:0]     push_vaddr0;
  logic [31:0]     push_vaddr1;
  logic [31:0]     push_instr0;
  logic [31:0]     push_instr1;
  logic            push_ex0;
  logic            push_ex1;
  logic            push_ready;
  logic [1:0]      pop_valid;
  logic [31:0]     pop_vaddr0;
  logic [31:0]     pop_vaddr1;
  logic [31:0]     pop_instr0;
  logic [31:0]     pop_instr1;
  logic            pop_ex0;
  logic            pop_ex1;
  logic [1:0]      pop_ack;
  logic [CntW-1:0] count;

  modport slave (
    input  flush, push_valid, push_vaddr0, push_vaddr1, push_instr0, push_instr1,
           push_ex0, push_ex1, pop_ack,
    output push_ready, pop_valid, pop_vaddr0, pop_vaddr1, pop_instr0, pop_instr1,
           pop_ex0, pop_ex1, count
  );

  modport master (
    output flush, push_valid, push_vaddr0, push_vaddr1, push_instr0, push_instr1,
           push_ex0, push_ex1, pop_ack,
    input  push_ready, pop_valid, pop_vaddr0, pop_vaddr1, pop_instr0, pop_instr1,
           pop_ex0, pop_ex1, count
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Dual-issue instruction fetch queue: circular buffer of DEPTH {vaddr, instr, ex}
// entries, accepting up to two instructions per cycle from fetch and presenting the
// two oldest to decode combinationally (first-word fall-through).
// Ports:
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset, priority over flush/push/pop
//   q   : instr_fetch_queue_if.slave bundle (push, pop, flush, count)
module instr_fetch_queue #(
  parameter int unsigned DEPTH = 8
) (
  input logic               clk,
  input logic               rst,
  instr_fetch_queue_if.slave q
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] ReadyMax = CntW'(DEPTH - 2);

  logic [31:0] vaddr_mem [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic        ex_mem    [DEPTH];

  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [1:0]      num_push, num_pop;
  logic [PtrW-1:0] head_p1, tail_p1;
  logic            wr0_en, wr1_en;

  assign head_p1 = head_q + PtrW'(1);
  assign tail_p1 = tail_q + PtrW'(1);

  // Readiness looks only at registered count so fetch never depends on decode's ack.
  assign q.push_ready   = (count_q <= ReadyMax);
  assign q.pop_valid[0] = (count_q >= CntW'(1));
  assign q.pop_valid[1] = (count_q >= CntW'(2));
  assign q.count        = count_q;

  assign q.pop_vaddr0 = vaddr_mem[head_q];
  assign q.pop_instr0 = instr_mem[head_q];
  assign q.pop_ex0    = ex_mem[head_q];
  assign q.pop_vaddr1 = vaddr_mem[head_p1];
  assign q.pop_instr1 = instr_mem[head_p1];
  assign q.pop_ex1    = ex_mem[head_p1];

  always_comb begin
    num_push = 2'd0;
    if (q.push_ready) begin
      case (q.push_valid)
        2'b11:   num_push = 2'd2;
        2'b01:   num_push = 2'd1;
        default: num_push = 2'd0;  // 2'b10 is illegal and writes nothing
      endcase
    end

    num_pop = 2'd0;
    if (q.pop_ack == 2'b11 && q.pop_valid == 2'b11) begin
      num_pop = 2'd2;
    end else if (q.pop_ack[0] && q.pop_valid[0]) begin
      num_pop = 2'd1;
    end

    wr0_en  = !q.flush && (num_push != 2'd0);
    wr1_en  = !q.flush && (num_push == 2'd2);
    head_d  = head_q + PtrW'(num_pop);
    tail_d  = tail_q + PtrW'(num_push);
    count_d = count_q + CntW'(num_push) - CntW'(num_pop);

    if (q.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is intentionally not reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (!rst && wr0_en) begin
      vaddr_mem[tail_q] <= q.push_vaddr0;
      instr_mem[tail_q] <= q.push_instr0;
      ex_mem[tail_q]    <= q.push_ex0;
    end
    if (!rst && wr1_en) begin
      vaddr_mem[tail_p1] <= q.push_vaddr1;
      instr_mem[tail_p1] <= q.push_instr1;
      ex_mem[tail_p1]    <= q.push_ex1;
    end
  end
endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of entries; power of two, at least 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 flush  input  1  discard all queued entries (branch mispredict, exception, ERET).
REQ-005 push_valid  input  2  per-slot valid from fetch; bit0 = older instruction.
REQ-006 push_vaddr0, push_vaddr1  input  32 each  virtual PC of slot 0 and slot 1.
REQ-007 push_instr0, push_instr1  input  32 each  instruction word of slot 0 and slot 1.
REQ-008 push_ex0, push_ex1  input  1 each  fetch address error / TLB exception flag per slot.
REQ-009 push_ready  output  1  queue can accept two instructions this cycle.
REQ-010 pop_valid  output  2  bit i = slot i holds a valid entry for decode.
REQ-011 pop_vaddr0, pop_vaddr1  output  32 each  PC presented to decode slot 0 and slot 1.
REQ-012 pop_instr0, pop_instr1  output  32 each  instruction presented to decode slot 0 and slot 1.
REQ-013 pop_ex0, pop_ex1  output  1 each  exception flag presented to decode slot 0 and slot 1.
REQ-014 pop_ack  input  2  decode consumed slot i this cycle.
REQ-015 count  output  log2(DEPTH)+1  current number of valid entries.

Function
REQ-016 Storage SHALL be a circular buffer of DEPTH entries {vaddr, instr, ex} with head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH.
REQ-017 push_ready SHALL be 1 iff count <= DEPTH-2; it is derived from registered count only, not from same-cycle pop_ack.
REQ-018 Number pushed: 2 if push_ready & push_valid==2'b11; 1 if push_ready & push_valid==2'b01; otherwise 0.
REQ-019 push_valid==2'b10 SHALL write nothing and leave state unchanged (illegal pattern).
REQ-020 Slot 0 SHALL be written at tail and slot 1 at tail+1 (mod DEPTH); tail advances by the number pushed.
REQ-021 Outputs are first-word fall-through: pop slot 0 = entry at head, pop slot 1 = entry at head+1 (mod DEPTH), read combinationally from storage.
REQ-022 pop_valid[0] = (count >= 1); pop_valid[1] = (count >= 2).
REQ-023 Number popped: 2 if pop_ack==2'b11 & pop_valid==2'b11; 1 if pop_ack[0] & pop_valid[0] and not the 2 case; otherwise 0. pop_ack[1] without pop_ack[0] SHALL be ignored.
REQ-024 head advances by number popped; count_next = count + pushed - popped; simultaneous push and pop in one cycle is legal at every count.
REQ-025 An entry pushed in cycle N SHALL first appear on pop outputs in cycle N+1 (no push-to-pop bypass).
REQ-026 Entries SHALL leave in push order; slot 0 before slot 1 within a push.
REQ-027 flush SHALL take priority over push and pop: next cycle head=0, tail=0, count=0; same-cycle push and pop are discarded.
REQ-028 When pop_valid[i]=0, pop_vaddr/instr/ex of slot i are don't-care; decode SHALL NOT act on them.
REQ-029 count SHALL never exceed DEPTH nor go below 0 under any legal or illegal input pattern.

Reset
REQ-030 On rst=1 at a clock edge: head=0, tail=0, count=0; next cycle pop_valid=2'b00, push_ready=1.
REQ-031 Storage array SHALL NOT be reset; rst has priority over flush, push, and pop.
REQ-032 rst asserted mid-operation SHALL discard all entries exactly as flush does.

Verification
REQ-033 After reset, push {0xBFC00000, 0x24020001} and {0xBFC00004, 0x00000000} with push_valid=11 -> next cycle pop_valid=11, pop_vaddr0=0xBFC00000, pop_vaddr1=0xBFC00004, count=2.
REQ-034 Push 2 per cycle with pop_ack=00 (DEPTH=8) -> count 2,4,6,8; push_ready drops to 0 when count=8 (after count=6 cycle accepts); further pushes ignored, count stays 8.
REQ-035 count=6, push_valid=11 and pop_ack=11 same cycle -> count stays 6; popped PCs are the two oldest; tail and head wrap past index 7 correctly over 10 such cycles.
REQ-036 count=5, flush=1 with push_valid=11 and pop_ack=11 -> next cycle count=0, pop_valid=00, push_ready=1.
REQ-037 count=1, pop_ack=11 -> only one entry popped, count=0; push_valid=10 at count=0 -> count stays 0; pop_ex0 carries push_ex0=1 unchanged.
